// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit.
// Op codes, FSM state constants and default operand width.
package mult_div_unit_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-FSM side bundle of the multiply/divide unit.
// master = control FSM / datapath, slave = the unit itself.
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             hilo_sel;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] res;

    modport master (
        output start, op, a, b, mthi, mtlo, hilo_sel,
        input  busy, done, div0, hi, lo, res
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, hilo_sel,
        output busy, done, div0, hi, lo, res
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Negate-if-sign helper: two's complement negation when neg_i is set.
// Used for operand magnitudes and for the final result correction.
module mult_div_unit_sign_fix #(
    parameter int N = 64
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + N'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// One bit per cycle on magnitudes, sign corrected in the FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               div0_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   mcand_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;

    logic               sgn_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sh_d;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign sgn_op = ~bus.op[0];

    mult_div_unit_sign_fix #(.N(WIDTH)) u_mag_a (
        .val_i (bus.a),
        .neg_i (sgn_op & bus.a[WIDTH-1]),
        .val_o (mag_a)
    );

    mult_div_unit_sign_fix #(.N(WIDTH)) u_mag_b (
        .val_i (bus.b),
        .neg_i (sgn_op & bus.b[WIDTH-1]),
        .val_o (mag_b)
    );

    mult_div_unit_sign_fix #(.N(2*WIDTH)) u_fix_prod (
        .val_i ({acc_q, sh_q}),
        .neg_i (neg_res_q),
        .val_o (prod)
    );

    mult_div_unit_sign_fix #(.N(WIDTH)) u_fix_quot (
        .val_i (sh_q),
        .neg_i (neg_res_q),
        .val_o (quot)
    );

    mult_div_unit_sign_fix #(.N(WIDTH)) u_fix_rem (
        .val_i (acc_q),
        .neg_i (neg_rem_q),
        .val_o (rem)
    );

    // One iteration: acc/sh hold {acc, mplier} or {remainder, quotient}
    always_comb begin
        sum      = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
        mul_step = {sum, sh_q[WIDTH-1:1]};
        shifted  = {acc_q, sh_q[WIDTH-1]};
        trial    = shifted - {1'b0, mcand_q};
        acc_d    = mul_step[2*WIDTH-1:WIDTH];
        sh_d     = mul_step[WIDTH-1:0];
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final HI/LO selection; divide by zero forces an all-ones quotient
    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = rem;
            fix_lo = dz_q ? '1 : quot;
        end
    end

    // Control FSM, iteration counter and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= CW'(WIDTH - 1);
                        acc_q     <= '0;
                        sh_q      <= mag_a;
                        mcand_q   <= mag_b;
                        is_div_q  <= bus.op[1];
                        neg_res_q <= sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_q <= sgn_op & bus.a[WIDTH-1];
                        dz_q      <= bus.op[1] & (bus.b == '0);
                    end else begin
                        if (bus.mthi) hi_q <= bus.a;
                        if (bus.mtlo) lo_q <= bus.a;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    div0_q  <= dz_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.res  = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
// Hand-computed vectors, one task per scenario.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   errs;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start for exactly one edge (the start edge).
    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // lat = number of edges from the start edge (inclusive) to done visible.
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (!bus.done) begin
            errs++;
            $display("FAIL timeout: done never seen after %0d edges", lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.busy, bus.done, bus.div0});
        end
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.res !== 32'h0) begin
            errs++;
            $display("FAIL reset_hilo: hi=%h lo=%h res=%h want 0",
                     bus.hi, bus.lo, bus.res);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_multu();
        int lat;
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vectors++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL multu_busy: got %b want 1", bus.busy);
        end
        wait_done(1, lat);
        vectors++;
        if (lat != 34) begin
            errs++;
            $display("FAIL multu_latency: got %0d want 34", lat);
        end
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errs++;
            $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001",
                     bus.hi, bus.lo);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.div0 !== 1'b0) begin
            errs++;
            $display("FAIL multu_flags: busy=%b div0=%b want 0 0",
                     bus.busy, bus.div0);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            errs++;
            $display("FAIL done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_mult_signed();
        int lat;
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(1, lat);
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            errs++;
            $display("FAIL mult_neg3x7: hi=%h lo=%h want ffffffff ffffffeb",
                     bus.hi, bus.lo);
        end
        tick();
        launch(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(1, lat);
        vectors++;
        if (bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
            errs++;
            $display("FAIL mult_minxmin: hi=%h lo=%h want 40000000 00000000",
                     bus.hi, bus.lo);
        end
        tick();
    endtask

    task automatic test_divide();
        int lat;
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errs++;
            $display("FAIL div_neg7by2: hi=%h lo=%h want ffffffff fffffffd",
                     bus.hi, bus.lo);
        end
        tick();
        launch(MDU_DIVU, 32'd100, 32'd7);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || lat != 34) begin
            errs++;
            $display("FAIL divu_100by7: hi=%0d lo=%0d lat=%0d want 2 14 34",
                     bus.hi, bus.lo, lat);
        end
        tick();
    endtask

    task automatic test_div_edge();
        int lat;
        launch(MDU_DIVU, 32'h0000_1234, 32'h0);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h0000_1234 ||
            bus.div0 !== 1'b1 || lat != 34) begin
            errs++;
            $display("FAIL div0: hi=%h lo=%h div0=%b lat=%0d want 1234 ffffffff 1 34",
                     bus.hi, bus.lo, bus.div0, lat);
        end
        tick();
        vectors++;
        if (bus.div0 !== 1'b0) begin
            errs++;
            $display("FAIL div0_pulse: got %b want 0", bus.div0);
        end
        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div0 !== 1'b0) begin
            errs++;
            $display("FAIL div_overflow: hi=%h lo=%h div0=%b want 0 80000000 0",
                     bus.hi, bus.lo, bus.div0);
        end
        tick();
    endtask

    task automatic test_ignore_and_move();
        int lat;
        launch(MDU_MULT, 32'd5, 32'd6);
        for (int i = 1; i < 10; i++) tick();
        bus.op    = MDU_MULTU;
        bus.a     = 32'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = 32'hAA;
        bus.mtlo  = 1'b1;
        tick();
        bus.mtlo  = 1'b0;
        vectors++;
        if (bus.lo !== 32'h8000_0000) begin
            errs++;
            $display("FAIL old_lo_midop: got %h want 80000000", bus.lo);
        end
        wait_done(12, lat);
        vectors++;
        if (bus.lo !== 32'd30 || bus.hi !== 32'd0 || lat != 34) begin
            errs++;
            $display("FAIL ignore_start: hi=%0d lo=%0d lat=%0d want 0 30 34",
                     bus.hi, bus.lo, lat);
        end
        tick();
        bus.a        = 32'h55;
        bus.mthi     = 1'b1;
        bus.hilo_sel = 1'b1;
        tick();
        bus.mthi = 1'b0;
        vectors++;
        if (bus.hi !== 32'h55 || bus.res !== 32'h55 || bus.lo !== 32'd30 ||
            bus.done !== 1'b0) begin
            errs++;
            $display("FAIL mthi: hi=%h res=%h lo=%h done=%b want 55 55 1e 0",
                     bus.hi, bus.res, bus.lo, bus.done);
        end
        bus.hilo_sel = 1'b0;
        #1;
        vectors++;
        if (bus.res !== 32'd30) begin
            errs++;
            $display("FAIL res_lo: got %h want 1e", bus.res);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        launch(MDU_DIV, 32'd1000, 32'd3);
        for (int i = 1; i < 15; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 ||
            bus.done !== 1'b0) begin
            errs++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h done=%b want 0 0 0 0",
                     bus.busy, bus.hi, bus.lo, bus.done);
        end
        tick();
        reset = 1'b1;
        tick();
        launch(MDU_MULTU, 32'd3, 32'd4);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'd12 || bus.hi !== 32'd0 || lat != 34) begin
            errs++;
            $display("FAIL post_reset_multu: hi=%0d lo=%0d lat=%0d want 0 12 34",
                     bus.hi, bus.lo, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(MDU_MULTU, 32'd7, 32'd8);
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'd56) begin
            errs++;
            $display("FAIL b2b_first: got %0d want 56", bus.lo);
        end
        launch(MDU_DIVU, 32'd100, 32'd7);
        vectors++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_accept: busy=%b want 1", bus.busy);
        end
        wait_done(1, lat);
        vectors++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || lat != 34) begin
            errs++;
            $display("FAIL b2b_second: hi=%0d lo=%0d lat=%0d want 2 14 34",
                     bus.hi, bus.lo, lat);
        end
        tick();
    endtask

    initial begin
        vectors      = 0;
        errs         = 0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        bus.mthi     = 1'b0;
        bus.mtlo     = 1'b0;
        bus.hilo_sel = 1'b0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_divide();
        test_div_edge();
        test_ignore_and_move();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
